// File: rtl/scratchpath_pkg.sv
// Shared address-map helpers, default sizes and IR field positions for the scratchpad register file.
// Optional write-through read bypass is enabled by defining SCRATCHPATH_WR_BYPASS_EN.
package scratchpath_pkg;

    localparam int unsigned NUM_GPR_DEF  = 32;
    localparam int unsigned NUM_TEMP_DEF = 4;
    localparam int unsigned PC_STEP_DEF  = 4;

    function automatic int unsigned addr_pc(input int unsigned num_gpr);
        return num_gpr;
    endfunction

    function automatic int unsigned addr_temp0(input int unsigned num_gpr);
        return num_gpr + 1;
    endfunction

    function automatic int unsigned addr_ir(input int unsigned num_gpr, input int unsigned num_temp);
        return num_gpr + num_temp + 1;
    endfunction

    // Default map
    localparam int unsigned ADDR_PC    = NUM_GPR_DEF;
    localparam int unsigned ADDR_TEMP0 = NUM_GPR_DEF + 1;
    localparam int unsigned ADDR_IR    = NUM_GPR_DEF + NUM_TEMP_DEF + 1;
    localparam int unsigned ADDR_LAST  = ADDR_IR;

    localparam int unsigned IR_OP_HI_MSB = 31;
    localparam int unsigned IR_OP_HI_LSB = 30;
    localparam int unsigned IR_RD_MSB    = 29;
    localparam int unsigned IR_RD_LSB    = 25;
    localparam int unsigned IR_OP_LO_MSB = 24;
    localparam int unsigned IR_OP_LO_LSB = 19;
    localparam int unsigned IR_RS1_MSB   = 18;
    localparam int unsigned IR_RS1_LSB   = 14;
    localparam int unsigned IR_I_BIT     = 13;
    localparam int unsigned IR_RS2_MSB   = 4;
    localparam int unsigned IR_RS2_LSB   = 0;

endpackage

// File: rtl/scratchpath_scoreboard.sv
// Busy-bit scoreboard: reserve/clear with reserve priority, sticky double-reserve error, A/B busy reads.
// With SCRATCHPATH_WR_BYPASS_EN a same-cycle clearing write hides the busy bit on the read ports.
module scratchpath_scoreboard #(
    parameter int unsigned NumRegs   = 38,
    parameter int unsigned AddrWidth = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic                 clr_busy_i,
    input  logic                 rsv_valid_i,
    input  logic [AddrWidth-1:0] rsv_addr_i,
    input  logic [AddrWidth-1:0] rda_addr_i,
    input  logic [AddrWidth-1:0] rdb_addr_i,
    output logic                 rda_busy_o,
    output logic                 rdb_busy_o,
    output logic                 rsv_err_o
);

    logic [NumRegs-1:0] busy_q, busy_d;
    logic               rsv_err_q, rsv_err_d;

    always_comb begin
        busy_d    = busy_q;
        rsv_err_d = rsv_err_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < NumRegs; i++) begin
            if (wr_en_i && clr_busy_i && wr_addr_i == AddrWidth'(i)) begin
                busy_d[i] = 1'b0;
            end
            // Reserve wins over a same-cycle clear
            if (rsv_valid_i && rsv_addr_i == AddrWidth'(i)) begin
                busy_d[i] = 1'b1;
                if (busy_q[i]) begin
                    rsv_err_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rda_busy_o = 1'b0;
        rdb_busy_o = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rda_addr_i == AddrWidth'(i)) rda_busy_o = busy_q[i];
            if (rdb_addr_i == AddrWidth'(i)) rdb_busy_o = busy_q[i];
        end
`ifdef SCRATCHPATH_WR_BYPASS_EN
        if (wr_en_i && clr_busy_i && rda_addr_i == wr_addr_i) rda_busy_o = 1'b0;
        if (wr_en_i && clr_busy_i && rdb_addr_i == wr_addr_i) rdb_busy_o = 1'b0;
`endif
    end

    assign rsv_err_o = rsv_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= '0;
            rsv_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rsv_err_q <= rsv_err_d;
        end
    end

endmodule

// File: rtl/scratchpath_regfile_sb.sv
// Scratchpad register file: GPRs (r0 constant), PC, temporaries and IR with two async reads,
// one sync write, PC auto-increment, IR decode and busy scoreboard. Option: SCRATCHPATH_WR_BYPASS_EN.
module scratchpath_regfile_sb
    import scratchpath_pkg::*;
#(
    parameter int unsigned       DATAWIDTH_BUS        = 32,
    parameter int unsigned       NUM_GPR              = NUM_GPR_DEF,
    parameter int unsigned       NUM_TEMP             = NUM_TEMP_DEF,
    parameter int unsigned       ADDR_WIDTH           = 6,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_0 = '0,
    parameter int unsigned       PC_STEP              = PC_STEP_DEF
) (
    input  logic                     uDataPath_CLOCK_50,
    input  logic                     uDATAPATH_RESET_InHigh,
    input  logic                     Wr_InLow,
    input  logic [ADDR_WIDTH-1:0]    Wr_Addr,
    input  logic [DATAWIDTH_BUS-1:0] Wr_Data,
    input  logic                     Wr_ClrBusy,
    input  logic                     Rsv_Valid,
    input  logic [ADDR_WIDTH-1:0]    Rsv_Addr,
    input  logic                     PC_Inc,
    input  logic [ADDR_WIDTH-1:0]    RdA_Addr,
    input  logic [ADDR_WIDTH-1:0]    RdB_Addr,
    output logic [DATAWIDTH_BUS-1:0] RdA_Data,
    output logic [DATAWIDTH_BUS-1:0] RdB_Data,
    output logic                     RdA_Busy,
    output logic                     RdB_Busy,
    output logic [7:0]               IR_OP,
    output logic [4:0]               IR_RD,
    output logic [4:0]               IR_RS1,
    output logic                     IR_IR13,
    output logic [4:0]               IR_RS2,
    output logic                     Rsv_Err
);

    localparam int unsigned AddrPc  = addr_pc(NUM_GPR);
    localparam int unsigned AddrIr  = addr_ir(NUM_GPR, NUM_TEMP);
    localparam int unsigned NumRegs = AddrIr + 1;

    logic [DATAWIDTH_BUS-1:0] regs_q [NumRegs];
    logic [DATAWIDTH_BUS-1:0] regs_d [NumRegs];
    logic                     wr_en;

    // r0 and unmapped addresses never take a write
    assign wr_en = !Wr_InLow && (Wr_Addr != '0) && (Wr_Addr <= ADDR_WIDTH'(AddrIr));

    always_comb begin
        regs_d = regs_q;
        if (PC_Inc) begin
            regs_d[AddrPc] = regs_q[AddrPc] + DATAWIDTH_BUS'(PC_STEP);
        end
        for (int i = 1; i < NumRegs; i++) begin
            if (wr_en && Wr_Addr == ADDR_WIDTH'(i)) regs_d[i] = Wr_Data;
        end
    end

    always_ff @(posedge uDataPath_CLOCK_50) begin
        if (uDATAPATH_RESET_InHigh) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= (i == 0) ? DATA_REGFIXED_INIT_0 : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        RdA_Data = '0;
        RdB_Data = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (RdA_Addr == ADDR_WIDTH'(i)) RdA_Data = regs_q[i];
            if (RdB_Addr == ADDR_WIDTH'(i)) RdB_Data = regs_q[i];
        end
`ifdef SCRATCHPATH_WR_BYPASS_EN
        if (wr_en && RdA_Addr == Wr_Addr) RdA_Data = Wr_Data;
        if (wr_en && RdB_Addr == Wr_Addr) RdB_Data = Wr_Data;
`endif
    end

    assign IR_OP   = {regs_q[AddrIr][IR_OP_HI_MSB:IR_OP_HI_LSB],
                      regs_q[AddrIr][IR_OP_LO_MSB:IR_OP_LO_LSB]};
    assign IR_RD   = regs_q[AddrIr][IR_RD_MSB:IR_RD_LSB];
    assign IR_RS1  = regs_q[AddrIr][IR_RS1_MSB:IR_RS1_LSB];
    assign IR_IR13 = regs_q[AddrIr][IR_I_BIT];
    assign IR_RS2  = regs_q[AddrIr][IR_RS2_MSB:IR_RS2_LSB];

    scratchpath_scoreboard #(
        .NumRegs   (NumRegs),
        .AddrWidth (ADDR_WIDTH)
    ) u_scoreboard (
        .clk_i       (uDataPath_CLOCK_50),
        .rst_i       (uDATAPATH_RESET_InHigh),
        .wr_en_i     (wr_en),
        .wr_addr_i   (Wr_Addr),
        .clr_busy_i  (Wr_ClrBusy),
        .rsv_valid_i (Rsv_Valid),
        .rsv_addr_i  (Rsv_Addr),
        .rda_addr_i  (RdA_Addr),
        .rdb_addr_i  (RdB_Addr),
        .rda_busy_o  (RdA_Busy),
        .rdb_busy_o  (RdB_Busy),
        .rsv_err_o   (Rsv_Err)
    );

endmodule
